// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer controllers.
//   ADDRSIZE / PTRW : default address width and pointer width (ADDRSIZE+1)
//   CODEW           : container width for the Gray/binary helpers
//   bin2gray        : binary -> Gray conversion
//   gray2bin        : Gray -> binary conversion
// Both helpers work on a zero-extended CODEW-bit container. Zero upper bits
// do not disturb either conversion, so a caller of any width up to CODEW
// extends its operand, calls the helper and truncates the result.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int ADDRSIZE = 3;
    localparam int PTRW     = ADDRSIZE + 1;
    localparam int CODEW    = 32;

    function automatic logic [CODEW-1:0] bin2gray(input logic [CODEW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and all Gray bits above it;
    // doubling shifts build that suffix XOR in log2(CODEW) steps.
    function automatic logic [CODEW-1:0] gray2bin(input logic [CODEW-1:0] g);
        logic [CODEW-1:0] b;
        b = g;
        for (int s = 1; s < CODEW; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// ---------------------------------------------------------------------------
// wptr_full_ctrl_if
// Write-side bundle between the producer and the write pointer controller.
//   Producer -> controller : winc, wq2_rptr, afull_thresh, wovf_clr
//   Controller -> producer : wen, waddr, wptr_gray, wfull, walmost_full,
//                            wlevel, woverflow
// The master modport is the producer side; the slave modport is the
// controller side.
// ---------------------------------------------------------------------------
interface wptr_full_ctrl_if #(
    parameter int ADDRSIZE = fifo_pkg::ADDRSIZE
) ();

    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   afull_thresh;
    logic                wovf_clr;

    logic                wen;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr_gray;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                woverflow;

    modport master (
        output winc, wq2_rptr, afull_thresh, wovf_clr,
        input  wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  winc, wq2_rptr, afull_thresh, wovf_clr,
        output wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow
    );

endinterface

// File: rtl/gray_ptr_counter.sv
// ---------------------------------------------------------------------------
// gray_ptr_counter
// Binary + Gray pointer pair that advances by one when inc is high.
// Shared by the write and read pointer controllers.
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : advance the pointer this cycle
//   bin        : current binary pointer (registered)
//   bin_next   : value bin takes on the next edge
//   gray_next  : Gray code of bin_next
//   gray       : current Gray pointer (registered, one bit change per step)
// ---------------------------------------------------------------------------
module gray_ptr_counter #(
    parameter int W = fifo_pkg::PTRW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_next,
    output logic [W-1:0] gray
);
    import fifo_pkg::*;

    assign bin_next  = bin + W'(inc);
    assign gray_next = W'(bin2gray(CODEW'(bin_next)));

    // Both codes are registered together so the Gray pointer leaving the
    // domain comes straight from a flop and never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// ---------------------------------------------------------------------------
// wptr_full_ctrl
// Write-domain pointer and full-flag controller for the asynchronous FIFO.
//   wclk, wrst_n : write clock, asynchronous active-low reset
//   bus (slave)  : winc, wq2_rptr, afull_thresh, wovf_clr in;
//                  wen, waddr, wptr_gray, wfull, walmost_full, wlevel,
//                  woverflow out
// The level and full flag are computed against the synchronised read
// pointer, so they can only over-estimate occupancy, never under-estimate.
// ---------------------------------------------------------------------------
module wptr_full_ctrl #(
    parameter int ADDRSIZE = fifo_pkg::ADDRSIZE
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    wptr_full_ctrl_if.slave      bus
);
    import fifo_pkg::*;

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] wgray;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] wlevel_r;
    logic          wen_i;
    logic          wfull_r;
    logic          walmost_r;
    logic          wovf_r;

    // Reset also blocks the RAM write so a request held across reset
    // cannot land in memory.
    assign wen_i = bus.winc & ~wfull_r & wrst_n;

    gray_ptr_counter #(.W(PW)) u_cnt (
        .clk       (wclk),
        .rst_n     (wrst_n),
        .inc       (wen_i),
        .bin       (wbin),
        .bin_next  (wbin_next),
        .gray_next (wgray_next),
        .gray      (wgray)
    );

    // Full when the write pointer is one lap ahead of the read pointer: in
    // Gray code that is the read pointer with its top two bits inverted.
    assign full_cmp   = {~bus.wq2_rptr[PW-1:PW-2], bus.wq2_rptr[PW-3:0]};
    assign rbin       = PW'(gray2bin(CODEW'(bus.wq2_rptr)));
    assign level_next = wbin_next - rbin;

    // Flags are registered from the next-pointer values so they line up
    // with the pointer that is being stored on the same edge.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wfull_r   <= 1'b0;
            wlevel_r  <= '0;
            walmost_r <= 1'b0;
        end else begin
            wfull_r   <= (wgray_next == full_cmp);
            wlevel_r  <= level_next;
            walmost_r <= (level_next >= bus.afull_thresh);
        end
    end

    // Sticky overflow; a new overflow in the clearing cycle must not be lost.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wovf_r <= 1'b0;
        end else if (bus.winc && wfull_r) begin
            wovf_r <= 1'b1;
        end else if (bus.wovf_clr) begin
            wovf_r <= 1'b0;
        end
    end

    assign bus.wen          = wen_i;
    assign bus.waddr        = wbin[ADDRSIZE-1:0];
    assign bus.wptr_gray    = wgray;
    assign bus.wfull        = wfull_r;
    assign bus.walmost_full = walmost_r;
    assign bus.wlevel       = wlevel_r;
    assign bus.woverflow    = wovf_r;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wptr_full_ctrl
// Directed self-checking bench for wptr_full_ctrl with ADDRSIZE = 3.
// ---------------------------------------------------------------------------
module tb_wptr_full_ctrl;

    logic wclk;
    logic wrst_n;

    int passCount;
    int checkCount;

    wptr_full_ctrl_if #(.ADDRSIZE(3)) bus ();

    wptr_full_ctrl #(.ADDRSIZE(3)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    // Free-running write clock, 10 time units per period.
    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the producer-side inputs.
    task automatic applyStimulus(input logic winc, input logic [3:0] rptr,
                                 input logic clr);
        bus.winc     = winc;
        bus.wq2_rptr = rptr;
        bus.wovf_clr = clr;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // All outputs must read zero, used during reset.
    task automatic checkAllZero(input string phase);
        checkOutput({phase, " wen"},          32'(bus.wen),          32'd0);
        checkOutput({phase, " waddr"},        32'(bus.waddr),        32'd0);
        checkOutput({phase, " wptr_gray"},    32'(bus.wptr_gray),    32'd0);
        checkOutput({phase, " wfull"},        32'(bus.wfull),        32'd0);
        checkOutput({phase, " walmost_full"}, 32'(bus.walmost_full), 32'd0);
        checkOutput({phase, " wlevel"},       32'(bus.wlevel),       32'd0);
        checkOutput({phase, " woverflow"},    32'(bus.woverflow),    32'd0);
    endtask

    initial begin
        logic [3:0] grayFill [8];
        logic [3:0] grayWrap [3];
        int         lvl;

        grayFill = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                     4'b0111, 4'b0101, 4'b0100, 4'b1100};
        grayWrap = '{4'b1001, 4'b1000, 4'b0000};
        passCount  = 0;
        checkCount = 0;

        // Reset held with a pending write request.
        wrst_n = 1'b0;
        bus.afull_thresh = 4'd6;
        applyStimulus(1'b1, 4'b0000, 1'b0);
        tick();
        tick();
        checkAllZero("reset");

        @(negedge wclk);
        wrst_n = 1'b1;
        #1;
        checkOutput("wen after release", 32'(bus.wen), 32'd1);

        // Fill from empty with the read pointer parked at zero.
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("fill%0d gray", i), 32'(bus.wptr_gray), 32'(grayFill[i]));
            checkOutput($sformatf("fill%0d level", i), 32'(bus.wlevel), 32'(i + 1));
            checkOutput($sformatf("fill%0d almost", i), 32'(bus.walmost_full),
                        32'((i + 1) >= 6));
            checkOutput($sformatf("fill%0d full", i), 32'(bus.wfull), 32'(i == 7));
        end
        checkOutput("full waddr wrap", 32'(bus.waddr), 32'd0);

        // Writes while full are blocked and flag overflow.
        checkOutput("blocked wen", 32'(bus.wen), 32'd0);
        tick();
        checkOutput("blocked gray", 32'(bus.wptr_gray), 32'b1100);
        checkOutput("blocked level", 32'(bus.wlevel), 32'd8);
        checkOutput("overflow set", 32'(bus.woverflow), 32'd1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        tick();
        checkOutput("overflow set wins", 32'(bus.woverflow), 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        tick();
        checkOutput("overflow cleared", 32'(bus.woverflow), 32'd0);
        checkOutput("still full", 32'(bus.wfull), 32'd1);

        // Reader catches up to binary 7 (Gray 0100).
        applyStimulus(1'b0, 4'b0100, 1'b0);
        tick();
        checkOutput("drain level", 32'(bus.wlevel), 32'd1);
        checkOutput("drain full", 32'(bus.wfull), 32'd0);
        checkOutput("drain almost", 32'(bus.walmost_full), 32'd0);

        // Climb to the almost-full threshold against a fixed read pointer.
        applyStimulus(1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            lvl = i + 2;
            tick();
            checkOutput($sformatf("climb lvl%0d level", lvl), 32'(bus.wlevel), 32'(lvl));
            checkOutput($sformatf("climb lvl%0d almost", lvl), 32'(bus.walmost_full),
                        32'(lvl >= 6));
            checkOutput($sformatf("climb lvl%0d full", lvl), 32'(bus.wfull), 32'd0);
        end

        // Reader jumps to binary 13 (Gray 1011); write across the 1111->0000 wrap.
        applyStimulus(1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("wrap%0d gray", i), 32'(bus.wptr_gray), 32'(grayWrap[i]));
            checkOutput($sformatf("wrap%0d level", i), 32'(bus.wlevel), 32'(i + 1));
            checkOutput($sformatf("wrap%0d full", i), 32'(bus.wfull), 32'd0);
        end

        // Two more writes bring the level to 5, then reset mid-cycle.
        tick();
        tick();
        checkOutput("pre-reset level", 32'(bus.wlevel), 32'd5);
        checkOutput("pre-reset waddr", 32'(bus.waddr), 32'd2);
        @(negedge wclk);
        wrst_n = 1'b0;
        #1;
        checkAllZero("midreset");

        applyStimulus(1'b1, 4'b0000, 1'b0);
        @(negedge wclk);
        wrst_n = 1'b1;
        tick();
        checkOutput("resume gray", 32'(bus.wptr_gray), 32'b0001);
        checkOutput("resume level", 32'(bus.wlevel), 32'd1);
        checkOutput("resume waddr", 32'(bus.waddr), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
